// File: rtl/vga_pkg.sv
// Shared screen geometry for the VGA timing generator and downstream drawers.
// Defaults describe 640x480@60 Hz with a 25 MHz pixel rate.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam bit          SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// Pixel-rate enable: a registered one-clock pulse every CLK_DIV system clocks.
// With CLK_DIV = 1 the pulse stays high from the first edge after reset.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_tick_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // The tick register looks at the next count so it is high while div_cnt == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      pixel_tick <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      pixel_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel coordinates, syncs, active-video flag and line/frame strobes.
// Reset parks the raster on its last pixel so the first tick enters (0,0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pixel_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int unsigned HT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC;
  localparam coord_t      X_LAST  = coord_t'(HT - 1);
  localparam coord_t      Y_LAST  = coord_t'(VT - 1);

  if (HT > COORD_MAX || VT > COORD_MAX || HT < 1 || VT < 1) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be within 1..%0d", COORD_MAX);
  end

  logic   tick;
  logic   x_wrap;
  logic   y_wrap;
  coord_t x_nxt;
  coord_t y_nxt;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (tick)
  );

  assign pixel_tick = tick;

  always_comb begin
    x_wrap = tick && (x == X_LAST);
    y_wrap = x_wrap && (y == Y_LAST);
    x_nxt  = x;
    y_nxt  = y;
    if (tick) begin
      x_nxt = x_wrap ? '0 : x + 1'b1;
    end
    if (x_wrap) begin
      y_nxt = y_wrap ? '0 : y + 1'b1;
    end
  end

  // Decodes use the next coordinates so every output changes on the same edge as x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= X_LAST;
      y           <= Y_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= in_window(x_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_window(y_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      video_on    <= in_window(x_nxt, 0, H_ACTIVE) && in_window(y_nxt, 0, V_ACTIVE);
      line_start  <= x_wrap;
      frame_start <= y_wrap;
      if (y_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every cycle against a
// closed-form raster model, plus hand-computed literal expectations and random resets.
module tb_vga_timing_gen;

  // CLK_DIV, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP
  localparam int PRM [3][9] = '{
    '{2, 640, 16, 96, 48, 480, 10, 2, 33},
    '{1,   4,  1,  2,  1,   1,  1, 1,  1},
    '{3,   5,  2,  3,  2,   3,  1, 2,  1}
  };
  localparam bit POL [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    longint x, y, fc;
    bit     hs, vs, vo, pt, ls, fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] ox [3];
  logic [9:0] oy [3];
  logic       ohs [3];
  logic       ovs [3];
  logic       ovo [3];
  logic       opt [3];
  logic       ols [3];
  logic       ofs [3];
  logic [7:0] ofc [3];

  int     n_checks = 0;
  int     n_pass   = 0;
  longint k = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .x(ox[0]), .y(oy[0]), .hsync(ohs[0]), .vsync(ovs[0]),
    .video_on(ovo[0]), .pixel_tick(opt[0]), .line_start(ols[0]), .frame_start(ofs[0]),
    .frame_count(ofc[0])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(ox[1]), .y(oy[1]), .hsync(ohs[1]), .vsync(ovs[1]),
    .video_on(ovo[1]), .pixel_tick(opt[1]), .line_start(ols[1]), .frame_start(ofs[1]),
    .frame_count(ofc[1])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x(ox[2]), .y(oy[2]), .hsync(ohs[2]), .vsync(ovs[2]),
    .video_on(ovo[2]), .pixel_tick(opt[2]), .line_start(ols[2]), .frame_start(ofs[2]),
    .frame_count(ofc[2])
  );

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Closed-form expectation after k edges: the pixel position advances on edges
  // k >= 2 with k % D == 0, starting from the parked (H_TOTAL-1, V_TOTAL-1).
  function automatic exp_t model(int d, longint kk);
    exp_t   e;
    longint dv, ht, vt, p, idx, hlo, vlo;
    bit     adv;
    dv  = PRM[d][0];
    ht  = PRM[d][1] + PRM[d][2] + PRM[d][3] + PRM[d][4];
    vt  = PRM[d][5] + PRM[d][6] + PRM[d][7] + PRM[d][8];
    hlo = PRM[d][1] + PRM[d][2];
    vlo = PRM[d][5] + PRM[d][6];
    p   = (kk < 2) ? 0 : (kk / dv - 1 / dv);
    idx = (p == 0) ? (ht * vt - 1) : ((p - 1) % (ht * vt));
    adv = (kk >= 2) && (kk % dv == 0);
    e.x  = idx % ht;
    e.y  = idx / ht;
    e.pt = (kk > 0) && (kk % dv == dv - 1);
    e.ls = adv && (e.x == 0);
    e.fs = adv && (idx == 0);
    e.fc = (p == 0) ? 0 : ((((p - 1) / (ht * vt)) + 1) % 256);
    e.hs = (e.x >= hlo && e.x < hlo + PRM[d][3]) ? POL[d] : !POL[d];
    e.vs = (e.y >= vlo && e.y < vlo + PRM[d][7]) ? POL[d] : !POL[d];
    e.vo = (e.x < PRM[d][1]) && (e.y < PRM[d][5]);
    return e;
  endfunction

  task automatic chk(input string name, input int d, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s dut%0d: actual=%0d required=%0d (k=%0d t=%0t)", name, d, act, req, k, $time);
  endtask

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e = model(d, k);
      chk("x",           d, ox[d],  e.x);
      chk("y",           d, oy[d],  e.y);
      chk("hsync",       d, ohs[d], e.hs);
      chk("vsync",       d, ovs[d], e.vs);
      chk("video_on",    d, ovo[d], e.vo);
      chk("pixel_tick",  d, opt[d], e.pt);
      chk("line_start",  d, ols[d], e.ls);
      chk("frame_start", d, ofs[d], e.fs);
      chk("frame_count", d, ofc[d], e.fc);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x",  0, ox[0], 799);
    chk("rst_y",  0, oy[0], 524);
    chk("rst_hs", 0, ohs[0], 1);
    chk("rst_vs", 0, ovs[0], 1);
    chk("rst_vo", 0, ovo[0], 0);
    #2 rst_n = 1'b1;

    for (int i = 1; i <= 8200; i++) begin
      @(negedge clk);
      case (i)
        1: begin chk("t1_tick", 0, opt[0], 1); chk("t1_x", 0, ox[0], 799); end
        2: begin
          chk("first_x", 0, ox[0], 0);   chk("first_y", 0, oy[0], 0);
          chk("first_vo", 0, ovo[0], 1); chk("first_fs", 0, ofs[0], 1);
          chk("first_ls", 0, ols[0], 1); chk("first_fc", 0, ofc[0], 1);
          chk("first_hs", 0, ohs[0], 1); chk("first_vs", 0, ovs[0], 1);
          chk("d1_first_x", 1, ox[1], 0); chk("d1_first_fs", 1, ofs[1], 1);
        end
        3:    begin chk("fs_drop", 0, ofs[0], 0); chk("ls_drop", 0, ols[0], 0); end
        1281: begin chk("x639", 0, ox[0], 639); chk("vo_639", 0, ovo[0], 1); end
        1282: begin chk("x640", 0, ox[0], 640); chk("vo_640", 0, ovo[0], 0); end
        1313: chk("hs_655", 0, ohs[0], 1);
        1314: begin chk("x656", 0, ox[0], 656); chk("hs_656", 0, ohs[0], 0); end
        1504: begin chk("x751", 0, ox[0], 751); chk("hs_751", 0, ohs[0], 0); end
        1506: begin chk("x752", 0, ox[0], 752); chk("hs_752", 0, ohs[0], 1); end
        1602: begin
          chk("line2_x", 0, ox[0], 0);  chk("line2_y", 0, oy[0], 1);
          chk("line2_ls", 0, ols[0], 1); chk("line2_fs", 0, ofs[0], 0);
        end
        8161: chk("fc_255", 1, ofc[1], 255);
        8162: begin chk("fc_wrap", 1, ofc[1], 0); chk("fc_wrap_fs", 1, ofs[1], 1); end
        default: ;
      endcase
    end

    // Asynchronous resets at random points within the clock period.
    repeat (6) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      rst_n = 1'b0;
      #1;
      chk("async_x",  0, ox[0], 799);
      chk("async_y",  0, oy[0], 524);
      chk("async_vo", 0, ovo[0], 0);
      chk("async_fc", 1, ofc[1], 0);
      chk("async_pt", 2, opt[2], 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat ($urandom_range(50, 2500)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
